// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the CPU memory port and the responder
interface mem_responder_if;
  logic        Req;
  logic        Wr;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Ready;
  logic        Err;
  logic        Busy;
  modport master (output Req, Wr, Addr, WData, input RData, Ready, Err, Busy);
  modport slave  (input Req, Wr, Addr, WData, output RData, Ready, Err, Busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word RAM behind a wait-state FSM, answering with a one-cycle Ready pulse
module mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            Clk,
  input logic            Reset,
  mem_responder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_wr;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [0:2**ADDR_W-1];
  logic              w_accept;
  logic              w_act;
  logic              w_wr;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_idx;
  logic              w_bad;
  assign w_accept = (r_state == IDLE) && bus.Req;
  // With zero wait states the action edge is the acceptance edge, so the live inputs stand in for the latches
  assign w_act   = (w_accept && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd0);
  assign w_wr    = (r_state == IDLE) ? bus.Wr    : r_wr;
  assign w_addr  = (r_state == IDLE) ? bus.Addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? bus.WData : r_wdata;
  assign w_idx   = w_addr[ADDR_W+1:2];
  assign w_bad   = (|w_addr[1:0]) || (|w_addr[31:ADDR_W+2]);
  // FSM, request latches, registered read data and error flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= (r_state == IDLE) ? (bus.Req ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
                 (r_state == WAIT) ? (r_cnt == 4'd0 ? RESP : WAIT) : IDLE;
      r_cnt   <= w_accept ? CNT_INIT : (r_state == WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
      if (w_accept) begin
        r_wr    <= bus.Wr;
        r_addr  <= bus.Addr;
        r_wdata <= bus.WData;
      end
      r_rdata <= (w_act && !w_wr && !w_bad) ? r_mem[w_idx] : r_rdata;
      r_err   <= w_act ? w_bad : 1'b0;
    end
  end
  // RAM write on the edge entering RESP; storage itself is never reset
  always_ff @(posedge Clk) begin
    if (w_act && w_wr && !w_bad && !Reset) r_mem[w_idx] <= w_wdata;
  end
  assign bus.RData = r_rdata;
  assign bus.Ready = (r_state == RESP);
  assign bus.Err   = r_err;
  assign bus.Busy  = (r_state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, RAM access, errors, reset abort and zero-wait build
module tb_mem_responder;
  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;
  mem_responder_if b ();
  mem_responder_if b0 ();
  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut  (.Clk(Clk), .Reset(Reset), .bus(b.slave));
  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (.Clk(Clk), .Reset(Reset), .bus(b0.slave));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input logic chg, input string tag);
    int n;
    int bc;
    b.Req = 1'b1; b.Wr = w; b.Addr = a; b.WData = d;
    @(posedge Clk); #1;
    if (chg) begin
      b.Addr = a ^ 32'h4; b.WData = ~d; b.Wr = ~w;
    end
    n = 0; bc = 0;
    while (!b.Ready && n < 20) begin
      bc += int'(b.Busy);
      @(posedge Clk); #1;
      n++;
    end
    bc += int'(b.Busy);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_busy_cycles"}, bc, 3);
    chk({tag, "_ready"}, {31'd0, b.Ready}, 1);
    chk({tag, "_err"}, {31'd0, b.Err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, b.RData, exp_rd);
    b.Req = 1'b0;
    @(posedge Clk); #1;
    chk({tag, "_ready_end"}, {31'd0, b.Ready}, 0);
    chk({tag, "_err_end"}, {31'd0, b.Err}, 0);
    chk({tag, "_busy_end"}, {31'd0, b.Busy}, 0);
  endtask
  task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    b0.Req = 1'b1; b0.Wr = w; b0.Addr = a; b0.WData = d;
    @(posedge Clk); #1;
    chk({tag, "_ready"}, {31'd0, b0.Ready}, 1);
    chk({tag, "_busy"}, {31'd0, b0.Busy}, 1);
    chk({tag, "_err"}, {31'd0, b0.Err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, b0.RData, exp_rd);
    b0.Req = 1'b0;
    @(posedge Clk); #1;
    chk({tag, "_ready_end"}, {31'd0, b0.Ready}, 0);
    chk({tag, "_busy_end"}, {31'd0, b0.Busy}, 0);
  endtask
  initial begin
    Reset = 1'b1;
    b.Req = 1'b0; b.Wr = 1'b0; b.Addr = 32'd0; b.WData = 32'd0;
    b0.Req = 1'b0; b0.Wr = 1'b0; b0.Addr = 32'd0; b0.WData = 32'd0;
    #2;
    chk("rst_ready", {31'd0, b.Ready}, 0);
    chk("rst_err", {31'd0, b.Err}, 0);
    chk("rst_busy", {31'd0, b.Busy}, 0);
    chk("rst_rdata", b.RData, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "wr10");
    txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd10");
    txn(1'b1, 32'h12, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, "wr_misalign");
    txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd10_again");
    txn(1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, "rd_oor");
    txn(1'b1, 32'h04, 32'h11111111, 32'hDEADBEEF, 1'b0, 1'b0, "wr04");
    txn(1'b1, 32'h0C, 32'h33333333, 32'hDEADBEEF, 1'b0, 1'b0, "wr0c");
    txn(1'b1, 32'h08, 32'h22222222, 32'hDEADBEEF, 1'b0, 1'b1, "wr08_chg");
    txn(1'b0, 32'h0C, 32'h0, 32'h33333333, 1'b0, 1'b0, "rd0c");
    txn(1'b1, 32'h20, 32'h0, 32'h33333333, 1'b0, 1'b0, "wr20_zero");
    b.Req = 1'b1; b.Wr = 1'b1; b.Addr = 32'h20; b.WData = 32'hAAAA5555;
    @(posedge Clk); #1;
    chk("abort_busy_wait", {31'd0, b.Busy}, 1);
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, b.Busy}, 0);
    chk("abort_ready", {31'd0, b.Ready}, 0);
    chk("abort_rdata", b.RData, 0);
    b.Req = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("post_rst_ready", {31'd0, b.Ready}, 0);
    chk("post_rst_busy", {31'd0, b.Busy}, 0);
    txn(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, "rd20_after_abort");
    b.Req = 1'b1; b.Wr = 1'b0; b.Addr = 32'h04;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("held1_ready", {31'd0, b.Ready}, 1);
    chk("held1_rdata", b.RData, 32'h11111111);
    b.Addr = 32'h08;
    @(posedge Clk); #1;
    chk("held_gap_ready", {31'd0, b.Ready}, 0);
    chk("held_gap_busy", {31'd0, b.Busy}, 0);
    @(posedge Clk); #1;
    chk("held2_busy", {31'd0, b.Busy}, 1);
    chk("held2_ready_early", {31'd0, b.Ready}, 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("held2_ready", {31'd0, b.Ready}, 1);
    chk("held2_rdata", b.RData, 32'h22222222);
    b.Req = 1'b0;
    @(posedge Clk); #1;
    chk("held_end_busy", {31'd0, b.Busy}, 0);
    txn0(1'b1, 32'h40, 32'h5A5A5A5A, 32'h0, 1'b0, "w0_wr40");
    txn0(1'b0, 32'h40, 32'h0, 32'h5A5A5A5A, 1'b0, "w0_rd40");
    txn0(1'b0, 32'h41, 32'h0, 32'h5A5A5A5A, 1'b1, "w0_rd_misalign");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory port. It serves the word read/write requests that the control FSM issues for instruction fetch, LW and SW.
- Contains a word-addressed RAM and a configurable wait-state counter. It returns a one-cycle Ready pulse with read data or an error flag.
- Sits between the CPU datapath address/data mux and the storage. It replaces a zero-latency memory so the control FSM can be exercised against real wait states.

Parameters:
- ADDR_W, 8: word-index width; RAM holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states between request acceptance and response, range 0..15.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  1  request valid; requester holds Req, Wr, Addr, WData stable until Ready.
- Wr  input  1  1 = word write, 0 = word read.
- Addr  input  32  byte address.
- WData  input  32  write data.
- RData  output  32  read data, registered.
- Ready  output  1  one-cycle completion pulse.
- Err  output  1  error status, valid when Ready = 1.
- Busy  output  1  high while a transaction is in flight (state != IDLE).

Behaviour:
- Reset is asynchronous and active-high on Reset; the clock is Clk.
- Reset values: state = IDLE, RData = 0, Ready = 0, Err = 0, Busy = 0, counter = 0, latched request registers = 0. RAM contents are not reset.
- Reset mid-transaction: the FSM returns to IDLE immediately. A pending write is dropped; RAM holds its pre-request value.
- FSM states and transitions:
  - IDLE: on an edge with Req = 1, latch Wr, Addr, WData. If WAIT_CYCLES = 0 go to RESP; otherwise go to WAIT with counter = WAIT_CYCLES - 1.
  - IDLE with Req = 0: stay in IDLE.
  - WAIT: if counter = 0 go to RESP; otherwise decrement the counter.
  - RESP: always go to IDLE. Req sampled during RESP is ignored.
- Consequence of the RESP→IDLE rule: there is at least one IDLE cycle between transactions. A Req held high continuously is accepted again on the edge leaving that IDLE cycle.
- Latency: with the request accepted at edge E0, Ready is high during the cycle after edge E0 + WAIT_CYCLES. For WAIT_CYCLES = 2, Ready is high in the 3rd cycle after the acceptance cycle.
- Action edge: the edge entering RESP.
  - Read: RData <= RAM[idx].
  - Write: RAM[idx] <= latched WData.
  - Err is registered on this same edge.
- RData holds its value until the next successful read. Writes and errored transactions leave RData unchanged.
- Ready = (state == RESP), a Moore output; exactly one cycle per transaction.
- Address decode:
  - idx = Addr[ADDR_W+1:2], taken from the latched address.
  - Misaligned if Addr[1:0] != 0.
  - Out-of-range if Addr[31:ADDR_W+2] != 0.
- Error handling: a misaligned or out-of-range request takes full latency, then Ready = 1 and Err = 1. There is no RAM write and no RData update.
- Err is 0 for good transactions and returns to 0 when Ready deasserts.
- Read-after-write: a read of a location in the transaction immediately following a write to it returns the new data.
- Input changes: Addr, Wr and WData changes after acceptance have no effect, because the latched copies are used.

Test Plan:
- WAIT_CYCLES = 2; write Addr = 0x10, WData = 0xDEADBEEF, then read Addr = 0x10 → each transaction gives Ready high exactly in the 3rd cycle after acceptance. The read returns RData = 0xDEADBEEF, Err = 0.
- Write Addr = 0x12 (misaligned), WData = 0x12345678, then read 0x10 → the write gives Ready = 1, Err = 1. The read returns 0xDEADBEEF; RData is unchanged by the errored write.
- ADDR_W = 8; read Addr = 0x400 (out of range) → Ready = 1, Err = 1, RData keeps its previous value, Busy high for 3 cycles.
- Reset asserted during WAIT of a write to 0x20 (prior content 0x0) → Ready never pulses. After reset release Busy = 0, and reading 0x20 returns 0x00000000.
- Req held high across two reads (0x04 then 0x08, with Addr changed after the first Ready) → two Ready pulses separated by one IDLE cycle; second RData = RAM[2].
- WAIT_CYCLES = 0 build; single read → Ready high in the cycle immediately after the acceptance edge, Busy high for exactly 1 cycle.
